mfcc_window_buf: RTL and testbench

- Upstream feeder for the BNN classifier core.
- Takes the serial MFCC coefficient stream, one 16-bit signed coefficient per accepted beat, and builds the sliding 5-tap windows that the conv stage consumes in parallel.
- Emits one window per conv position (36 per 40-coefficient frame), with position index and end-of-frame marker, under valid/ready flow control.

---
 rtl/mfcc_window_buf.sv | 151 +++++++++++++++
 tb/tb_mfcc_window_buf.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mfcc_window_buf.sv
// Sliding K-tap window builder over the serial MFCC coefficient stream.
// Define MFCC_WIN_ZERO_PAD_EN for "same" zero padding (N_COEF windows per frame, FLUSH tail).
module mfcc_window_buf #(
  parameter int DW     = 16,
  parameter int K      = 5,
  parameter int N_COEF = 40,
  parameter int IDX_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sof,
  input  logic [DW-1:0]         in_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [K*DW-1:0]       win_data,
  output logic [IDX_W-1:0]      win_idx,
  output logic                  win_last,
  output logic                  sof_err
);

`ifdef MFCC_WIN_ZERO_PAD_EN
  localparam int PAD = (K - 1) / 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEF - 1);
  localparam logic [DW-1:0]    ZERO     = '0;
`else
  localparam int PAD = 0;
`endif
  localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0] FIRST_C = IDX_W'(K - PAD);
  localparam logic [IDX_W-1:0] N_C     = IDX_W'(N_COEF);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
`ifdef MFCC_WIN_ZERO_PAD_EN
    , FLUSH
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [K-1:0][DW-1:0]   taps_q, taps_d;
  logic [IDX_W-1:0]       ccnt_q, ccnt_d, cnt_inc, emit_idx;
  logic                   ready_en, flushing, accept, xfer;
  logic                   emit, emit_last, err;

`ifdef MFCC_WIN_ZERO_PAD_EN
  assign flushing = (state_q == FLUSH);
`else
  assign flushing = 1'b0;
`endif

  assign in_ready = ready_en && !flushing && (!win_valid || win_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = win_valid && win_ready;
  assign cnt_inc  = ccnt_q + ONE;

  always_comb begin
    state_d   = state_q;
    taps_d    = taps_q;
    ccnt_d    = ccnt_q;
    emit      = 1'b0;
    emit_idx  = '0;
    emit_last = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && in_sof) begin
          taps_d        = '0;
          taps_d[K-1]   = in_data;
          ccnt_d        = ONE;
          state_d       = FILL;
        end
      end
      // FILL and RUN share one path: a window is due once cnt reaches K-PAD.
      FILL, RUN: begin
        if (accept) begin
          if (in_sof) begin
            err         = 1'b1;
            taps_d      = '0;
            taps_d[K-1] = in_data;
            ccnt_d      = ONE;
            state_d     = FILL;
          end else begin
            taps_d = {in_data, taps_q[K-1:1]};
            ccnt_d = cnt_inc;
            if (cnt_inc >= FIRST_C) begin
              emit     = 1'b1;
              emit_idx = cnt_inc - FIRST_C;
              state_d  = RUN;
              if (cnt_inc == N_C) begin
                ccnt_d = '0;
`ifdef MFCC_WIN_ZERO_PAD_EN
                state_d = FLUSH;
`else
                emit_last = 1'b1;
                state_d   = IDLE;
`endif
              end
            end
          end
        end
      end
`ifdef MFCC_WIN_ZERO_PAD_EN
      FLUSH: begin
        if (xfer) begin
          taps_d   = {ZERO, taps_q[K-1:1]};
          emit     = 1'b1;
          emit_idx = win_idx + ONE;
          if (emit_idx == LAST_IDX) begin
            emit_last = 1'b1;
            state_d   = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      taps_q    <= '0;
      ccnt_q    <= '0;
      ready_en  <= 1'b0;
      sof_err   <= 1'b0;
      win_valid <= 1'b0;
      win_data  <= '0;
      win_idx   <= '0;
      win_last  <= 1'b0;
    end else begin
      state_q  <= state_d;
      taps_q   <= taps_d;
      ccnt_q   <= ccnt_d;
      ready_en <= 1'b1;
      sof_err  <= err;
      if (emit) begin
        win_valid <= 1'b1;
        win_data  <= taps_d;
        win_idx   <= emit_idx;
        win_last  <= emit_last;
      end else if (xfer) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mfcc_window_buf.sv
// Randomized/directed bench for mfcc_window_buf against a frame-level window model.
module tb_mfcc_window_buf;
  localparam int DW = 16, K = 5, N = 40, IW = 6;
`ifdef MFCC_WIN_ZERO_PAD_EN
  localparam int PAD = (K - 1) / 2;
`else
  localparam int PAD = 0;
`endif
  localparam int NWIN = N - K + 1 + 2 * PAD;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_sof = 1'b0, win_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic in_ready, win_valid, win_last, sof_err;
  logic [K*DW-1:0] win_data;
  logic [IW-1:0] win_idx;

  mfcc_window_buf #(.DW(DW), .K(K), .N_COEF(N), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_data(in_data), .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_idx(win_idx), .win_last(win_last), .sof_err(sof_err));

  always #5 clk = ~clk;

  typedef struct { bit sof; logic [DW-1:0] d; bit lastc; } beat_t;
  typedef struct { logic [K*DW-1:0] d; int idx; bit last; } win_t;

  beat_t bq[$];
  win_t  wq[$];
  int errors = 0, checks = 0, exp_err = 0, seen_err = 0, cyc = 0;
  logic [DW-1:0] frame [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [K*DW-1:0] obs, input logic [K*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the first n beats of a frame and every window those beats fully determine.
  task automatic add_frame(input int n);
    win_t w;
    int hi, p;
    for (int i = 0; i < n; i++) bq.push_back('{sof: (i == 0), d: frame[i], lastc: (i == N - 1)});
    hi = (n == N) ? NWIN - 1 : n - K + PAD;
    for (int j = 0; j <= hi; j++) begin
      w.d = '0;
      for (int t = 0; t < K; t++) begin
        p = j + t - PAD;
        if (p >= 0 && p < n) w.d[DW*t +: DW] = frame[p];
      end
      w.idx  = j;
      w.last = (n == N) && (j == NWIN - 1);
      wq.push_back(w);
    end
  endtask

  task automatic run(input int rmode, input int vmode, input bit stop_on_beats, input bit consec);
    int budget = 3000;
    int first = -1;
    bit stalled = 0, flushing = 0;
    logic [K*DW-1:0] held_d = '0;
    logic [IW-1:0] held_idx = '0;
    win_t w;
    beat_t b;
    while ((bq.size() > 0 || (!stop_on_beats && wq.size() > 0)) && budget > 0) begin
      @(negedge clk);
      win_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~win_ready : 1'($urandom_range(0, 1));
      if (bq.size() > 0) begin
        in_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        in_sof   = bq[0].sof;
        in_data  = bq[0].d;
      end else begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = DW'($urandom);
      end
      #1;
      if (sof_err) seen_err++;
      if (stalled) begin
        chk("hold_valid", win_valid, 1);
        chk("hold_data", win_data, held_d);
        chk("hold_idx", win_idx, held_idx);
      end
      if (win_valid && !win_ready) chk("ready_backpressure", in_ready, 0);
      if (flushing) chk("flush_ready_low", in_ready, 0);
      if (win_valid && win_ready) begin
        if (wq.size() == 0) chk("unexpected_window", win_valid, 0);
        else begin
          w = wq.pop_front();
          chk("win_data", win_data, w.d);
          chk("win_idx", win_idx, w.idx);
          chk("win_last", win_last, w.last);
          if (w.idx == 0) first = cyc;
          if (w.last) begin
            if (consec) chk("consecutive", cyc - first, NWIN - 1);
            flushing = 0;
          end
        end
      end
      stalled  = win_valid && !win_ready;
      held_d   = win_data;
      held_idx = win_idx;
      if (in_valid && in_ready) begin
        b = bq.pop_front();
        if (PAD > 0 && b.lastc) flushing = 1;
      end
      budget--;
    end
    if (budget == 0) chk("timeout_left", bq.size() + wq.size(), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_data", win_data, 0);
    chk("rst_win_idx", win_idx, 0);
    chk("rst_win_last", win_last, 0);
    chk("rst_sof_err", sof_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", in_ready, 1);

    // ascending frame, full throughput
    for (int i = 0; i < N; i++) frame[i] = DW'(i + 1);
    add_frame(N);
    run(0, 0, 0, 1);
    chk("no_sof_err", seen_err, exp_err);

    // same frame with win_ready toggling
    add_frame(N);
    run(1, 0, 0, 0);

    // negative data
    for (int i = 0; i < N; i++) frame[i] = DW'(-i);
    add_frame(N);
    run(0, 0, 0, 0);

    // beats without sof in IDLE are dropped
    for (int i = 0; i < 3; i++) bq.push_back('{sof: 1'b0, d: DW'(7), lastc: 1'b0});
    for (int i = 0; i < N; i++) frame[i] = DW'(i + 1);
    add_frame(N);
    run(0, 0, 0, 0);

    // early sof after c19 aborts frame A, frame B completes
    for (int i = 0; i < N; i++) frame[i] = DW'(100 + i);
    add_frame(20);
    exp_err++;
    for (int i = 0; i < N; i++) frame[i] = DW'(200 + i);
    add_frame(N);
    run(0, 0, 0, 0);
    chk("sof_err_count", seen_err, exp_err);

    // random data, random valid/ready
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) frame[i] = DW'($urandom);
      add_frame(N);
    end
    run(2, 1, 0, 0);

    // reset mid-frame with a window pending
    for (int i = 0; i < N; i++) frame[i] = DW'(300 + i);
    add_frame(11);
    run(0, 0, 1, 0);
    win_ready = 1'b0;
    #2;
    chk("pending_before_rst", win_valid, 1);
    chk("pending_count", wq.size(), 1);
    wq.delete();
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", win_valid, 0);
    chk("rst_mid_ready", in_ready, 0);
    chk("rst_mid_idx", win_idx, 0);
    win_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst2", in_ready, 1);
    for (int i = 0; i < N; i++) frame[i] = DW'(i + 1);
    add_frame(N);
    run(0, 0, 0, 1);
    chk("final_sof_err", seen_err, exp_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
